// File: rtl/dram_bank.sv
// -----------------------------------------------------------------------------
// dram_bank
//   Behavioural DRAM bank: a DEPTH x DATA_W array in which every row carries a
//   retention timer. A row whose timer has reached zero has lost its contents.
//   Reads of such a row return zero and flag decay_err. A two-step refresh
//   sequencer (REF_ACT, REF_RST) walks the rows round-robin. It reloads the
//   timer of a row that is still live; an expired row stays expired.
//
//   Optional feature macro: DRAM_AUTO_REFRESH_EN
//     When defined, a free-running counter raises a refresh request every
//     REF_PERIOD cycles, in addition to the manual refresh input.
//
// Parameters
//   DATA_W      word width
//   ADDR_W      address width, DEPTH = 2**ADDR_W rows
//   RETENTION   cycles a row stays live after a write or refresh (>= 2)
//   REF_PERIOD  cycles between auto-refresh requests (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   req        access request, accepted on an edge where req && ready
//   we         1 = write, 0 = read
//   addr       row address
//   din        write data
//   refresh    manual refresh request pulse
//   ready      bank can accept an access this cycle
//   rvalid     one-cycle read-data-valid pulse
//   dout       read data, held between reads
//   decay_err  pulses with rvalid when the row read had expired
//   ref_busy   refresh sequence in progress
// -----------------------------------------------------------------------------
module dram_bank #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int RETENTION  = 64,
  parameter int REF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              refresh,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] dout,
  output logic              decay_err,
  output logic              ref_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TMR_W = $clog2(RETENTION + 1);
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(RETENTION);

  if (RETENTION < 2 || REF_PERIOD < 1) begin : g_param_check
    $error("dram_bank: RETENTION must be >= 2 and REF_PERIOD >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REF_ACT = 2'd1,
    REF_RST = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ref_ptr;
  logic                ref_pending;
  logic                row_live_q;   // liveness of ref_ptr sampled in REF_ACT
  logic                ref_tick;     // auto-refresh request (0 when disabled)
  logic                ref_req;
  logic                start_ref;
  logic                accept;
  logic                wr_acc;
  logic                rd_acc;
  logic                rd_live;

  logic [DATA_W-1:0]   mem   [DEPTH];
  logic [TMR_W-1:0]    timer [DEPTH];

  // ---------------------------------------------------------------------------
  // Optional periodic refresh request
  // ---------------------------------------------------------------------------
`ifdef DRAM_AUTO_REFRESH_EN
  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign ref_tick = (tick_cnt == CNT_LAST);
`else
  assign ref_tick = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign ref_req   = refresh | ref_tick;
  assign start_ref = (state == IDLE) && ref_pending;
  assign ready     = rst_n && (state == IDLE) && !ref_pending;
  assign ref_busy  = (state != IDLE);

  // A refresh request arriving on the same edge as an access wins: the access
  // is not taken, and ready drops next cycle because ref_pending is then set.
  assign accept  = ready && req && !ref_req;
  assign wr_acc  = accept && we;
  assign rd_acc  = accept && !we;
  assign rd_live = (timer[addr] != '0);

  // ---------------------------------------------------------------------------
  // Refresh sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers sample the pre-edge values of each other, whatever the order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ref_ptr     <= '0;
      ref_pending <= 1'b0;
      row_live_q  <= 1'b0;
    end else begin
      // A request landing on the edge that consumes the pending flag is a new
      // request and survives; requests while already pending merge.
      ref_pending <= ref_req | (ref_pending & ~start_ref);

      unique case (state)
        IDLE: begin
          if (ref_pending) state <= REF_ACT;
        end
        REF_ACT: begin
          row_live_q <= (timer[ref_ptr] != '0);
          state      <= REF_RST;
        end
        REF_RST: begin
          ref_ptr <= ref_ptr + 1'b1;   // wraps mod DEPTH
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Retention timers: reload on write or on refresh of a live row, otherwise
  // count down and stick at zero. The reload takes precedence over the
  // decrement. Writes and REF_RST never coincide, since ready is low in
  // REF_RST.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((wr_acc && addr == ADDR_W'(i)) ||
            (state == REF_RST && row_live_q && ref_ptr == ADDR_W'(i))) begin
          timer[i] <= RELOAD;
        end else if (timer[i] != '0) begin
          timer[i] <= timer[i] - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Its contents are masked by the timers,
  // which are all cleared by reset, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[addr] <= din;
  end

  // ---------------------------------------------------------------------------
  // Read return path: one-cycle latency; dout holds between reads
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid    <= 1'b0;
      decay_err <= 1'b0;
      dout      <= '0;
    end else begin
      rvalid    <= rd_acc;
      decay_err <= rd_acc && !rd_live;
      if (rd_acc) dout <= rd_live ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_dram_bank.sv
// -----------------------------------------------------------------------------
// tb_dram_bank
//   Self-checking bench for dram_bank in its default build (auto refresh off).
//   The reference model tracks, per row, the edge of its last write/refresh.
//   It treats a row as live while the edge distance is at most RETENTION.
//   The refresh sequence is tracked by the edge on which it started.
//   Inputs are driven and outputs checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_dram_bank;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int RET    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] din = '0;
  logic              refresh = 1'b0;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] dout;
  logic              decay_err;
  logic              ref_busy;

  always #5 clk = ~clk;

  dram_bank #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RETENTION (RET),
    .REF_PERIOD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .refresh  (refresh),
    .ready    (ready),
    .rvalid   (rvalid),
    .dout     (dout),
    .decay_err(decay_err),
    .ref_busy (ref_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          e = 0;                 // index of the last processed rising edge
  bit          loaded  [DEPTH];       // row written/refreshed since reset
  int          load_at [DEPTH];       // edge of the last write/refresh
  logic [7:0]  mdata   [DEPTH];
  bit          m_pend = 1'b0;
  int          seq_e  = -1000;        // edge on which a refresh sequence began
  bit          m_latch = 1'b0;
  int          m_ptr = 0;
  bit          m_rvalid = 1'b0;
  bit          m_derr = 1'b0;
  logic [7:0]  m_dout = '0;
  bit          m_acc = 1'b0;

  function automatic bit m_live(input int r, input int at);
    return loaded[r] && (at - load_at[r] <= RET);
  endfunction

  // Sequence begun at edge S occupies edges S+1 and S+2; IDLE again at S+3.
  function automatic bit m_idle(input int at);
    return at >= seq_e + 3;
  endfunction

  function automatic void model_edge(input bit rn, input bit rq, input bit w,
                                     input int a, input logic [7:0] d, input bit rf);
    bit idle, take;
    e++;
    if (!rn) begin
      for (int r = 0; r < DEPTH; r++) loaded[r] = 1'b0;
      m_pend = 1'b0; m_ptr = 0; seq_e = -1000;
      m_rvalid = 1'b0; m_derr = 1'b0; m_dout = '0; m_acc = 1'b0;
      return;
    end
    idle = m_idle(e);
    if (e == seq_e + 1) m_latch = m_live(m_ptr, e);
    if (e == seq_e + 2) begin
      if (m_latch) begin
        load_at[m_ptr] = e;
        loaded[m_ptr]  = 1'b1;
      end
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_acc    = idle && !m_pend && rq && !rf;
    m_rvalid = m_acc && !w;
    m_derr   = 1'b0;
    if (m_rvalid) begin
      if (m_live(a, e)) m_dout = mdata[a];
      else begin
        m_dout = '0;
        m_derr = 1'b1;
      end
    end
    if (m_acc && w) begin
      mdata[a]   = d;
      load_at[a] = e;
      loaded[a]  = 1'b1;
    end
    take = idle && m_pend;
    if (take) seq_e = e;
    m_pend = (m_pend && !take) || rf;
  endfunction

  task automatic compare_outputs(input bit rn);
    check("ready",     32'(ready),       32'(rn && m_idle(e + 1) && !m_pend));
    check("ref_busy",  32'(ref_busy),    32'(!m_idle(e + 1)));
    check("rvalid",    32'(rvalid),      32'(m_rvalid));
    check("decay_err", 32'(decay_err),   32'(m_derr));
    check("dout",      32'(dout),        32'(m_dout));
    check("ref_ptr",   32'(dut.ref_ptr), 32'(m_ptr));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the
  // next falling edge.
  task automatic step(input bit rn, input bit rq, input bit w, input int a,
                      input logic [7:0] d, input bit rf);
    rst_n = rn; req = rq; we = w; addr = ADDR_W'(a); din = d; refresh = rf;
    @(posedge clk);
    model_edge(rn, rq, w, a, d, rf);
    @(negedge clk);
    compare_outputs(rn);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  // Hold req until accepted, within a bounded number of cycles.
  task automatic access(input bit w, input int a, input logic [7:0] d);
    int tries;
    tries = 0;
    do begin
      step(1'b1, 1'b1, w, a, d, 1'b0);
      tries++;
    end while (!m_acc && tries < 40);
    if (!m_acc) check("access_timeout", 32'(ready), 32'd1);
    req = 1'b0;
  endtask

  task automatic read_expect(input string tag, input int a, input logic [7:0] exp_d,
                             input bit exp_e);
    access(1'b0, a, 8'h00);
    check({tag, "_rvalid"}, 32'(rvalid),    32'd1);
    check({tag, "_dout"},   32'(dout),      32'(exp_d));
    check({tag, "_derr"},   32'(decay_err), 32'(exp_e));
  endtask

  logic [7:0] vals [DEPTH];
  int         ptr0;

  initial begin
    // ---- reset ----
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
      check("rst_ready", 32'(ready), 32'd0);
    end
    idle_cycles(1);
    check("rel_ready", 32'(ready), 32'd1);

    // ---- read of a never-written row ----
    read_expect("t1", 5, 8'h00, 1'b1);

    // ---- write then read after 10 idle cycles ----
    access(1'b1, 2, 8'hA5);
    idle_cycles(10);
    read_expect("t2", 2, 8'hA5, 1'b0);

    // ---- expiry boundary: W+64 live, W+65 expired ----
    access(1'b1, 1, 8'h3C);
    idle_cycles(RET - 1);
    read_expect("t3_live", 1, 8'h3C, 1'b0);
    access(1'b1, 1, 8'h3C);
    idle_cycles(RET);
    read_expect("t3_dead", 1, 8'h00, 1'b1);

    // ---- manual refresh keeps all rows alive ----
    for (int r = 0; r < DEPTH; r++) begin
      vals[r] = 8'(r * 37 + 5);
      access(1'b1, r, vals[r]);
    end
    ptr0 = m_ptr;
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 8'h00, (k % 7) == 0);
      if (k < 28) check("t4_ready", 32'(ready), ((k % 7) < 3) ? 32'd0 : 32'd1);
      if ((k % 7) == 3) check("t4_ptr", 32'(dut.ref_ptr), 32'((ptr0 + k / 7 + 1) % DEPTH));
    end
    for (int r = 0; r < DEPTH; r++) read_expect("t4", r, vals[r], 1'b0);

    // ---- write colliding with refresh is rejected, then accepted ----
    access(1'b1, 6, 8'h11);
    step(1'b1, 1'b1, 1'b1, 6, 8'h5A, 1'b1);
    check("t5_ready", 32'(ready),    32'd0);
    check("t5_busy0", 32'(ref_busy), 32'd0);
    idle_cycles(1);
    check("t5_busy1", 32'(ref_busy), 32'd1);
    idle_cycles(1);
    check("t5_busy2", 32'(ref_busy), 32'd1);
    idle_cycles(1);
    check("t5_busy3", 32'(ref_busy), 32'd0);
    check("t5_rdy3",  32'(ready),    32'd1);
    read_expect("t5_old", 6, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b1, 6, 8'h5A, 1'b1);
    access(1'b1, 6, 8'h5A);
    read_expect("t5_new", 6, 8'h5A, 1'b0);

    // ---- reset during REF_ACT ----
    step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle_cycles(1);
    check("t6_in_act", 32'(ref_busy), 32'd1);
    step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    idle_cycles(1);
    check("t6_busy",  32'(ref_busy), 32'd0);
    check("t6_ready", 32'(ready),    32'd1);
    for (int r = 0; r < DEPTH; r++) read_expect("t6", r, 8'h00, 1'b1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      if ((i % 300) == 299) idle_cycles(70);
      step(($urandom % 400) != 0, ($urandom % 3) == 0, $urandom % 2,
           int'($urandom % DEPTH), 8'($urandom), ($urandom % 12) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_bank.md
# dram_bank

Parametrised behavioural DRAM bank with per-row retention timers, a two-cycle refresh sequencer and a ready/valid access port. Replaces the fixed 8×8 DRAM model. Rows lose their contents when not rewritten or refreshed within `RETENTION` cycles. An optional internal scheduler issues refreshes periodically, so the bank models a real array behind a simple controller.

## Interface
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 3: address width; `DEPTH = 2**ADDR_W` rows.
- `RETENTION`, 64: cycles a row holds data after a write or refresh; must be ≥ 2.
- `REF_PERIOD`, 4: cycles between auto-refresh requests; must be ≥ 1. Used only with `DRAM_AUTO_REFRESH_EN`.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `req  in  1`: access request.
- `we  in  1`: 1 = write, 0 = read; sampled with `req`.
- `addr  in  ADDR_W`: row address.
- `din  in  DATA_W`: write data.
- `refresh  in  1`: manual refresh request pulse.
- `ready  out  1`: access is accepted on an edge where `req && ready`.
- `rvalid  out  1`: read data valid, one-cycle pulse.
- `dout  out  DATA_W`: read data, held between reads.
- `decay_err  out  1`: asserts with `rvalid` when the row read had expired.
- `ref_busy  out  1`: refresh sequence in progress.

## Operation
- State per row:
  - `mem[DEPTH]`, `DATA_W` bits.
  - `timer[DEPTH]`, `$clog2(RETENTION+1)` bits, unsigned.
  - Row is live iff its timer ≠ 0.
- Timers:
  - Every cycle, each timer > 0 decrements by 1.
  - A reload in the same cycle overrides the decrement.
  - Timers never wrap below 0.
- Write accepted: `mem[addr] <= din`, `timer[addr] <= RETENTION`.
- Read accepted: next cycle drives `rvalid=1`.
  - `dout = mem[addr]` if the timer was ≠ 0 in the acceptance cycle.
  - Otherwise `dout = 0` and `decay_err = 1`.
- Refresh request sources:
  - The `refresh` pulse.
  - The auto tick, when configured.
  - Both set a single `ref_pending` flag; multiple requests while pending merge into one.
- FSM states: `IDLE`, `REF_ACT`, `REF_RST`.
  - `IDLE -> REF_ACT` when `ref_pending`; this clears `ref_pending`.
  - `REF_ACT`: latch whether row `ref_ptr` is live; always goes to `REF_RST` next.
  - `REF_RST`: if the latched row was live, reload its timer to `RETENTION`; an expired row stays expired. Then `ref_ptr <= ref_ptr + 1` (wraps mod `DEPTH`) and go to `IDLE`.
- `ready = (state == IDLE) && !ref_pending`. Refresh has priority over a same-cycle request.
- `ref_busy = (state != IDLE)`.
- A `req` without `ready` is ignored, not queued. The master holds `req` until it is accepted.

## Timing
- Reset (`rst_n = 0` at an edge):
  - State `IDLE`; all timers 0; `ref_ptr = 0`; `ref_pending = 0`; auto counter 0.
  - `rvalid = 0`, `decay_err = 0`, `dout = 0`, `ref_busy = 0`.
  - `ready = 0` while `rst_n = 0`; `ready = 1` from the first cycle after release.
  - `mem` is not cleared; expired timers mask its contents.
- Reset mid-refresh aborts the sequence with no timer reload.
- Read latency: 1 cycle from the acceptance edge to `rvalid`. Back-to-back reads give one result per cycle.
- Write latency: a read accepted on the cycle after a write returns the new data.
- Refresh latency:
  - A `refresh` pulse seen in `IDLE` drops `ready` next cycle.
  - Busy occupies 2 cycles; `ready` returns on the third cycle after the pulse edge, unless another refresh is pending.
- Expiry boundary:
  - A row written at edge W is live on cycles W+1 … W+RETENTION.
  - A read accepted on cycle W+RETENTION+1 sees it expired.
- Reload in `REF_RST` and decrement on the same row in the same cycle: the reload wins.

## Configuration
- `DRAM_AUTO_REFRESH_EN` defined:
  - A `$clog2(REF_PERIOD)`-bit counter runs from reset release.
  - On reaching `REF_PERIOD-1` it sets `ref_pending` and wraps to 0.
  - The `refresh` input stays functional and merges with the tick.
- Undefined: the counter is not synthesised; refresh comes only from `refresh`.
- Row lifetime under auto refresh is roughly `DEPTH·(REF_PERIOD+2)` cycles, which must stay below `RETENTION`. This is a verification check, not enforced in RTL.

## Test plan
- Reset, then read row 5 → `rvalid=1`, `dout=0x00`, `decay_err=1` one cycle later.
- Write 0xA5 to row 2, read row 2 after 10 idle cycles (macro off) → `dout=0xA5`, `decay_err=0`.
- Write 0x3C to row 1, read at cycle W+64 → 0x3C; rewrite, then read at W+65 → 0x00 with `decay_err=1`.
- Macro off: write all 8 rows; pulse `refresh` every 7 cycles; read all rows after 200 cycles → written values intact. Check `ready=0` for 3 cycles per pulse and that `ref_ptr` wraps 7→0.
- `req` (write) and `refresh` arrive in the same cycle → write not accepted; `ref_busy` high 2 cycles; write accepted when `ready` returns.
- Assert `rst_n=0` during `REF_ACT`, then release → `ref_busy=0`, `ready=1`, and all rows read as 0x00 with `decay_err=1`.
